dac_sched: RTL and testbench

Timestamped stimulus playback: the transmit-side counterpart to the sampling ADC. Accepts (timestamp, value) pairs from the emulation host, queues them, and drives a held signed output that updates exactly when the shared emulation time reaches each stamp. Sits between the host stimulus port and the channel/TX model, and uses the same `time_curr` bus the ADC samples.

---
 rtl/dac_pkg.sv | 14 +
 rtl/dac_sched_sync_fifo.sv | 65 ++++++
 rtl/dac_sched.sv | 79 +++++++
 tb/tb_dac_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared widths and the queue entry layout for the timestamped DAC scheduler.
package dac_pkg;

   localparam int SIG_BITS   = 16;
   localparam int TIME_BITS  = 32;
   localparam int DEPTH_BITS = 4;

   // "time" is a reserved word, so the stamp field is called tstamp
   typedef struct packed {
      logic        [TIME_BITS-1:0] tstamp;
      logic signed [SIG_BITS-1:0]  sig;
   } dac_entry_t;

endpackage

// File: rtl/dac_sched_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head word and an inferred RAM body.
module sync_fifo #(
   parameter int width      = 48,
   parameter int depth_bits = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [width-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [width-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [depth_bits:0]   count
);

   localparam int DEPTH = 2 ** depth_bits;

   logic [width-1:0]      mem_q [DEPTH];
   logic [width-1:0]      head_q;
   logic [depth_bits-1:0] wr_ptr_q, wr_ptr_d;
   logic [depth_bits-1:0] rd_ptr_q, rd_ptr_d;
   logic [depth_bits:0]   count_q, count_d;
   logic                  wr_ok, rd_ok;

   assign full  = (count_q == (depth_bits+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = head_q;

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + depth_bits'(wr_ok);
      rd_ptr_d = rd_ptr_q + depth_bits'(rd_ok);
      count_d  = count_q + (depth_bits+1)'(wr_ok) - (depth_bits+1)'(rd_ok);
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem_q[wr_ptr_q] <= wr_data;
   end

   // Head prefetches the next read address; bypass when that slot is being written now
   always_ff @(posedge clk) begin
      if (wr_ok && (wr_ptr_q == rd_ptr_d))
         head_q <= wr_data;
      else
         head_q <= mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dac_sched.sv
// Timestamped playback: queues (stamp, value) pairs and applies each one when time_curr reaches its stamp.
module dac_sched
   import dac_pkg::*;
#(
   parameter int sig_bits   = SIG_BITS,
   parameter int time_bits  = TIME_BITS,
   parameter int depth_bits = DEPTH_BITS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic        [time_bits-1:0] time_curr,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic        [time_bits-1:0] in_time,
   input  logic signed [sig_bits-1:0]  in_sig,
   output logic signed [sig_bits-1:0]  sig,
   output logic                        late,
   output logic        [depth_bits:0]  level
);

   localparam int ENTRY_BITS = time_bits + sig_bits;

   logic [ENTRY_BITS-1:0]      fifo_head;
   logic                       fifo_full, fifo_empty;
   logic [depth_bits:0]        fifo_count;
   logic [time_bits-1:0]       head_time, delta;
   logic signed [sig_bits-1:0] head_sig;
   logic                       push, due;
   logic signed [sig_bits-1:0] sig_q, sig_d;
   logic                       late_q, late_d;

   assign in_ready  = rst_n && !fifo_full;
   assign push      = in_valid && in_ready;
   assign head_time = fifo_head[ENTRY_BITS-1 -: time_bits];
   assign head_sig  = fifo_head[sig_bits-1:0];

   // Modular distance: a stamp up to half the time range in the past counts as due
   assign delta = time_curr - head_time;
   assign due   = !fifo_empty && !delta[time_bits-1];

   sync_fifo #(
      .width      (ENTRY_BITS),
      .depth_bits (depth_bits)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data ({in_time, in_sig}),
      .rd_en   (due && rst_n),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      sig_d  = sig_q;
      late_d = 1'b0;
      if (due) begin
         sig_d  = head_sig;
         late_d = (delta != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q  <= '0;
         late_q <= 1'b0;
      end else begin
         sig_q  <= sig_d;
         late_q <= late_d;
      end
   end

   assign sig   = sig_q;
   assign late  = late_q;
   assign level = fifo_count;

endmodule

// File: tb/tb_dac_sched.sv
// Scoreboard bench for dac_sched: queue-based reference model feeds expectations to a per-cycle monitor.
module tb_dac_sched;
   import dac_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [31:0]          time_curr = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [31:0]          in_time = '0;
   logic signed [15:0]   in_sig = '0;
   logic signed [15:0]   sig;
   logic                 late;
   logic [4:0]           level;

   always #5 clk = ~clk;

   dac_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .time_curr (time_curr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_time   (in_time),
      .in_sig    (in_sig),
      .sig       (sig),
      .late      (late),
      .level     (level)
   );

   typedef struct {
      logic signed [15:0] sig;
      logic               late;
      int                 level;
      logic               rdy;
      int                 cyc;
   } exp_t;

   exp_t        exp_q[$];
   dac_entry_t  mq[$];
   logic signed [15:0] m_sig = '0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          armed = 0;
   logic [31:0] tc;

   task automatic chk(input string name, input int c, input logic signed [31:0] got,
                      input logic signed [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, want);
      end
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge
   exp_t e;
   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         if (armed) begin
            checks++;
            errors++;
            $display("FAIL underflow cycle=%0d got=empty expected=entry", cyc);
         end
      end else begin
         e = exp_q.pop_front();
         chk("sig",      e.cyc, 32'(sig),        32'(e.sig));
         chk("late",     e.cyc, {31'b0, late},   {31'b0, e.late});
         chk("level",    e.cyc, {27'b0, level},  e.level);
         chk("in_ready", e.cyc, {31'b0, in_ready}, {31'b0, e.rdy});
      end
   end

   // Drive one cycle at the falling edge and predict the state after the next rising edge
   task automatic step(input logic rst, input logic v, input logic [31:0] ts,
                       input logic signed [15:0] sv, input logic [31:0] tcv);
      logic [31:0] d;
      logic        m_late;
      bit          accept;
      exp_t        x;
      rst_n     = rst;
      in_valid  = v;
      in_time   = ts;
      in_sig    = sv;
      time_curr = tcv;
      m_late    = 1'b0;
      if (!rst) begin
         mq.delete();
         m_sig = '0;
      end else begin
         accept = v && (mq.size() < 16);
         if (mq.size() > 0) begin
            d = tcv - mq[0].tstamp;
            if (d < 32'h8000_0000) begin
               m_sig  = mq[0].sig;
               m_late = (d != 0);
               void'(mq.pop_front());
            end
         end
         if (accept)
            mq.push_back('{tstamp: ts, sig: sv});
      end
      x.sig   = m_sig;
      x.late  = m_late;
      x.level = mq.size();
      x.rdy   = rst && (mq.size() < 16);
      x.cyc   = cyc;
      exp_q.push_back(x);
      armed = 1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      logic [31:0]        stamps [3];
      logic signed [15:0] vals   [3];
      stamps = '{32'd10, 32'd20, 32'd20};
      vals   = '{16'sd100, -16'sd5, 16'sd7};
      @(negedge clk);

      // Reset held with in_valid asserted
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd5, 16'sd55, 32'd0);

      // Basic playback, including an equal-stamp pair
      for (int t = 0; t < 26; t++)
         step(1'b1, t < 3, t < 3 ? stamps[t] : 32'd0, t < 3 ? vals[t] : 16'sd0, t);

      // Fill to 16 entries, hold a 17th offer, then release time to 1000
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'd1000, 16'(i + 1), 32'd0);
      for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 32'd1000, 16'(200 + i), 32'd1000);
      for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 32'd0, 16'sd0, 32'd1000);

      // Late entry
      step(1'b1, 1'b1, 32'd30, 16'sd3, 32'd50);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 16'sd0, 32'd50);

      // Wrap-around: stamp 4 pushed while time sits just below the wrap
      tc = 32'hFFFF_FFFA;
      step(1'b1, 1'b1, 32'd4, 16'sd9, tc);
      for (int i = 0; i < 12; i++) begin
         tc = tc + 1;
         step(1'b1, 1'b0, 32'd0, 16'sd0, tc);
      end

      // Mid-run reset discards queued entries
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'(200 + i), 16'(-(i + 40)), 32'd100);
      step(1'b0, 1'b0, 32'd0, 16'sd0, 32'd100);
      for (int t = 198; t < 210; t++) step(1'b1, 1'b0, 32'd0, 16'sd0, t);

      // Randomised traffic with occasional out-of-order stamps and rare resets
      tc = 32'd5000;
      for (int i = 0; i < 2000; i++) begin
         logic        r;
         logic        v;
         logic [31:0] ts;
         r  = ($urandom_range(0, 299) != 0);
         v  = ($urandom_range(0, 2) != 0);
         ts = tc + $urandom_range(0, 30) - 4;
         step(r, v, ts, 16'($urandom), tc);
         tc = tc + $urandom_range(0, 2);
      end

      armed = 0;
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain got=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
